cgra_bram_if_nport: RTL and testbench

- Parametrised successor to the fixed two-data-port CGRA BRAM interface.
- Bridges NUM_PORTS CGRA load/store channels to NUM_PORTS external BRAM ports through a registered request/response pipeline.
- Owns the software handshake: Computation_Start/Computation_Done, array start pulse, Busy tracking, watchdog timeout and a run-cycle counter.
- Sits between the PE torus and the host-visible BRAMs; single clock domain.

---
 rtl/cgra_bram_if_nport_if.sv | 52 +++++
 rtl/cgra_bram_if_nport.sv | 186 ++++++++++++++++++
 tb/tb_cgra_bram_if_nport.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_bram_if_nport_if.sv
// Bus bundle between the CGRA load/store channels, the external BRAM ports and
// the software start/done handshake. The design side uses master, the environment uses slave.
interface cgra_bram_if_nport_if #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 32,
  parameter int BYTE_LEN  = 4,
  parameter int NUM_PORTS = 2,
  parameter int CWIDTH    = 32
);
  // BRAM side
  logic [NUM_PORTS-1:0]                 Port_Clk;
  logic [NUM_PORTS-1:0]                 Port_Rst;
  logic [NUM_PORTS-1:0]                 Port_En;
  logic [NUM_PORTS-1:0][BYTE_LEN-1:0]   Port_Wen;
  logic [NUM_PORTS-1:0][AWIDTH-1:0]     Port_Addr;
  logic [NUM_PORTS-1:0][DWIDTH-1:0]     Port_Data_To_Bram;
  logic [NUM_PORTS-1:0][DWIDTH-1:0]     Port_Data_From_Bram;

  // array side
  logic [NUM_PORTS-1:0]                 Cgra_Req;
  logic [NUM_PORTS-1:0][BYTE_LEN-1:0]   Cgra_Wen;
  logic [NUM_PORTS-1:0][AWIDTH-1:0]     Cgra_Addr;
  logic [NUM_PORTS-1:0][DWIDTH-1:0]     Cgra_Store;
  logic [NUM_PORTS-1:0][DWIDTH-1:0]     Cgra_Load;
  logic [NUM_PORTS-1:0]                 Cgra_Load_Valid;
  logic                                 PE_Array_Busy;
  logic                                 Array_Start;

  // software handshake
  logic                                 Computation_Start;
  logic                                 Computation_Done;
  logic                                 Timeout_Flag;
  logic [CWIDTH-1:0]                    Run_Cycles;

  modport master (
    output Port_Clk, Port_Rst, Port_En, Port_Wen, Port_Addr, Port_Data_To_Bram,
    input  Port_Data_From_Bram,
    input  Cgra_Req, Cgra_Wen, Cgra_Addr, Cgra_Store, PE_Array_Busy,
    output Cgra_Load, Cgra_Load_Valid, Array_Start,
    input  Computation_Start,
    output Computation_Done, Timeout_Flag, Run_Cycles
  );

  modport slave (
    input  Port_Clk, Port_Rst, Port_En, Port_Wen, Port_Addr, Port_Data_To_Bram,
    output Port_Data_From_Bram,
    output Cgra_Req, Cgra_Wen, Cgra_Addr, Cgra_Store, PE_Array_Busy,
    input  Cgra_Load, Cgra_Load_Valid, Array_Start,
    output Computation_Start,
    input  Computation_Done, Timeout_Flag, Run_Cycles
  );
endinterface

// File: rtl/cgra_bram_if_nport.sv
// N-port CGRA <-> BRAM bridge: per-port registered request/load pipelines plus the
// start/done run controller with watchdog and run-cycle counter.

module cgra_bram_if_nport_lane #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 32,
  parameter int BYTE_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                accept,
  input  logic                req,
  input  logic [BYTE_LEN-1:0] wen,
  input  logic [AWIDTH-1:0]   addr,
  input  logic [DWIDTH-1:0]   store,
  input  logic [DWIDTH-1:0]   rd_data,
  output logic                en,
  output logic [BYTE_LEN-1:0] wen_q,
  output logic [AWIDTH-1:0]   addr_q,
  output logic [DWIDTH-1:0]   data_q,
  output logic [DWIDTH-1:0]   load,
  output logic                load_valid
);
  localparam int SHIFT  = $clog2(BYTE_LEN);
  // stage 0: request register, 1: BRAM read, 2: load output register
  localparam int STAGES = 2;

  logic              take;
  logic              rd_issue;
  logic [STAGES:0]   vld_pipe;

  assign take     = accept & req;
  assign rd_issue = take & ~(|wen);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      wen_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      load     <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_issue};
      if (take) begin
        en     <= 1'b1;
        wen_q  <= wen;
        addr_q <= addr << SHIFT;
        data_q <= store;
      end else begin
        en    <= 1'b0;
        wen_q <= '0;
      end
      if (vld_pipe[STAGES-1]) load <= rd_data;
    end
  end

  assign load_valid = vld_pipe[STAGES];
endmodule

module cgra_bram_if_nport #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 32,
  parameter int BYTE_LEN  = 4,
  parameter int NUM_PORTS = 2,
  parameter int TIMEOUT   = 0,
  parameter int CWIDTH    = 32
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  cgra_bram_if_nport_if.master  bus
);
  typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_t;

  localparam logic [CWIDTH-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CWIDTH'(TIMEOUT - 1);

  state_t              state;
  logic [CWIDTH-1:0]   cnt;
  logic                seen_busy;
  logic                drain_last;
  logic                array_start;
  logic                comp_done;
  logic                timeout_flag;
  logic [CWIDTH-1:0]   run_cycles;

  logic                accept;
  logic                busy_fall;
  logic                wd_hit;

  assign accept    = (state == RUN) || (state == DRAIN);
  assign busy_fall = seen_busy & ~bus.PE_Array_Busy;
  // a Busy-fall in the same cycle as the watchdog limit counts as a normal finish
  assign wd_hit    = (TIMEOUT != 0) && (cnt == TO_LAST) && !busy_fall;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      seen_busy    <= 1'b0;
      drain_last   <= 1'b0;
      array_start  <= 1'b0;
      comp_done    <= 1'b0;
      timeout_flag <= 1'b0;
      run_cycles   <= '0;
    end else begin
      array_start <= 1'b0;
      case (state)
        IDLE: if (bus.Computation_Start) begin
          state        <= ARM;
          array_start  <= 1'b1;
          timeout_flag <= 1'b0;
          cnt          <= '0;
          seen_busy    <= 1'b0;
        end
        ARM: state <= RUN;
        RUN: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (bus.PE_Array_Busy) seen_busy <= 1'b1;
          if (busy_fall || wd_hit) begin
            state        <= DRAIN;
            run_cycles   <= cnt;
            timeout_flag <= wd_hit;
            drain_last   <= 1'b0;
          end
        end
        // two cycles so requests issued on the last RUN cycle still reach the BRAM
        DRAIN: begin
          if (drain_last) begin
            state     <= DONE;
            comp_done <= 1'b1;
          end else begin
            drain_last <= 1'b1;
          end
        end
        DONE: if (!bus.Computation_Start) begin
          state     <= IDLE;
          comp_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [NUM_PORTS-1:0]               en;
  logic [NUM_PORTS-1:0][BYTE_LEN-1:0] wen_q;
  logic [NUM_PORTS-1:0][AWIDTH-1:0]   addr_q;
  logic [NUM_PORTS-1:0][DWIDTH-1:0]   data_q;
  logic [NUM_PORTS-1:0][DWIDTH-1:0]   load;
  logic [NUM_PORTS-1:0]               load_valid;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    cgra_bram_if_nport_lane #(
      .DWIDTH   (DWIDTH),
      .AWIDTH   (AWIDTH),
      .BYTE_LEN (BYTE_LEN)
    ) u_lane (
      .clk        (Clk),
      .rst_n      (Resetn),
      .accept     (accept),
      .req        (bus.Cgra_Req[p]),
      .wen        (bus.Cgra_Wen[p]),
      .addr       (bus.Cgra_Addr[p]),
      .store      (bus.Cgra_Store[p]),
      .rd_data    (bus.Port_Data_From_Bram[p]),
      .en         (en[p]),
      .wen_q      (wen_q[p]),
      .addr_q     (addr_q[p]),
      .data_q     (data_q[p]),
      .load       (load[p]),
      .load_valid (load_valid[p])
    );
  end

  assign bus.Port_Clk          = {NUM_PORTS{Clk}};
  assign bus.Port_Rst          = {NUM_PORTS{~Resetn}};
  assign bus.Port_En           = en;
  assign bus.Port_Wen          = wen_q;
  assign bus.Port_Addr         = addr_q;
  assign bus.Port_Data_To_Bram = data_q;
  assign bus.Cgra_Load         = load;
  assign bus.Cgra_Load_Valid   = load_valid;
  assign bus.Array_Start       = array_start;
  assign bus.Computation_Done  = comp_done;
  assign bus.Timeout_Flag      = timeout_flag;
  assign bus.Run_Cycles        = run_cycles;
endmodule

// File: tb/tb_cgra_bram_if_nport.sv
// Directed bench for cgra_bram_if_nport: 4 ports, 20-cycle watchdog, simple per-port BRAM model.
module tb_cgra_bram_if_nport;
  localparam int DW = 32, AW = 32, BL = 4, NP = 4, TO = 20, CW = 32;

  logic Clk = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clk = ~Clk;

  cgra_bram_if_nport_if #(.DWIDTH(DW), .AWIDTH(AW), .BYTE_LEN(BL), .NUM_PORTS(NP), .CWIDTH(CW)) bus ();

  cgra_bram_if_nport #(
    .DWIDTH(DW), .AWIDTH(AW), .BYTE_LEN(BL), .NUM_PORTS(NP), .TIMEOUT(TO), .CWIDTH(CW)
  ) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // BRAM model: a read enable returns this port's word one cycle later
  logic [NP-1:0][DW-1:0] bram_rd;
  always @(posedge Clk or negedge Resetn) begin
    if (!Resetn) bus.Port_Data_From_Bram <= '0;
    else
      for (int p = 0; p < NP; p++)
        if (bus.Port_En[p] && bus.Port_Wen[p] == '0) bus.Port_Data_From_Bram[p] <= bram_rd[p];
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.Computation_Done) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_done: Done=%b after %0d cycles, required 1", bus.Computation_Done, budget);
    end
  endtask

  task automatic test_reset;
    bus.Cgra_Req = '0; bus.Cgra_Wen = '0; bus.Cgra_Addr = '0; bus.Cgra_Store = '0;
    bus.PE_Array_Busy = 1'b0; bus.Computation_Start = 1'b0; bram_rd = '0;
    Resetn = 1'b0;
    tick(); tick();
    n_chk++;
    if ({bus.Port_En, bus.Port_Wen, bus.Port_Addr, bus.Port_Data_To_Bram} !== '0) begin
      n_fail++; $display("FAIL reset_bram_side: En=%h Wen=%h Addr=%h, required all 0",
                         bus.Port_En, bus.Port_Wen, bus.Port_Addr);
    end
    n_chk++;
    if ({bus.Cgra_Load, bus.Cgra_Load_Valid, bus.Array_Start, bus.Computation_Done,
         bus.Timeout_Flag, bus.Run_Cycles} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: Load_Valid=%b Start=%b Done=%b TO=%b Run=%0d, required 0",
                         bus.Cgra_Load_Valid, bus.Array_Start, bus.Computation_Done,
                         bus.Timeout_Flag, bus.Run_Cycles);
    end
    n_chk++;
    if (bus.Port_Rst !== 4'hf) begin
      n_fail++; $display("FAIL reset_port_rst: got %b, required 1111", bus.Port_Rst);
    end
    Resetn = 1'b1;
    tick();
    n_chk++;
    if (bus.Port_Rst !== 4'h0) begin
      n_fail++; $display("FAIL release_port_rst: got %b, required 0000", bus.Port_Rst);
    end
  endtask

  // cycle 1 = Array_Start cycle; Busy high in cycles 3..12
  task automatic test_handshake;
    bus.Computation_Start = 1'b1;
    tick();
    n_chk++;
    if (bus.Array_Start !== 1'b1) begin
      n_fail++; $display("FAIL hs_array_start: got %b, required 1", bus.Array_Start);
    end
    for (int c = 2; c <= 17; c++) begin
      tick();
      bus.PE_Array_Busy = (c >= 3 && c <= 12);
      if (c == 2) begin
        n_chk++;
        if (bus.Array_Start !== 1'b0) begin
          n_fail++; $display("FAIL hs_start_pulse_width: got %b, required 0", bus.Array_Start);
        end
      end
      if (c == 15) begin
        n_chk++;
        if (bus.Computation_Done !== 1'b0) begin
          n_fail++; $display("FAIL hs_done_early: got %b, required 0", bus.Computation_Done);
        end
      end
      if (c == 16) begin
        n_chk++;
        if (bus.Computation_Done !== 1'b1) begin
          n_fail++; $display("FAIL hs_done: got %b, required 1", bus.Computation_Done);
        end
        n_chk++;
        if (bus.Run_Cycles !== 32'd11) begin
          n_fail++; $display("FAIL hs_run_cycles: got %0d, required 11", bus.Run_Cycles);
        end
        n_chk++;
        if (bus.Timeout_Flag !== 1'b0) begin
          n_fail++; $display("FAIL hs_timeout_flag: got %b, required 0", bus.Timeout_Flag);
        end
      end
      if (c == 17) begin
        n_chk++;
        if (bus.Computation_Done !== 1'b1) begin
          n_fail++; $display("FAIL hs_done_hold: got %b, required 1", bus.Computation_Done);
        end
      end
    end
    bus.Computation_Start = 1'b0;
    tick();
    n_chk++;
    if (bus.Computation_Done !== 1'b0) begin
      n_fail++; $display("FAIL hs_done_drop: got %b, required 0", bus.Computation_Done);
    end
    tick();
  endtask

  // leaves the run in RUN with Busy high; test_parallel_writes finishes it
  task automatic test_load_latency;
    bus.Computation_Start = 1'b1;
    tick(); tick();
    bus.PE_Array_Busy = 1'b1;
    bram_rd[2] = 32'hDEADBEEF;
    bus.Cgra_Req = 4'b0100; bus.Cgra_Wen[2] = 4'b0000; bus.Cgra_Addr[2] = 32'h10;
    tick();
    bus.Cgra_Req = '0;
    n_chk++;
    if (bus.Port_En !== 4'b0100) begin
      n_fail++; $display("FAIL ld_port_en: got %b, required 0100", bus.Port_En);
    end
    n_chk++;
    if (bus.Port_Addr[2] !== 32'h40) begin
      n_fail++; $display("FAIL ld_port_addr: got %h, required 00000040", bus.Port_Addr[2]);
    end
    n_chk++;
    if (bus.Port_Wen[2] !== 4'b0000) begin
      n_fail++; $display("FAIL ld_port_wen: got %b, required 0000", bus.Port_Wen[2]);
    end
    tick();
    n_chk++;
    if (bus.Cgra_Load_Valid !== 4'b0000 || bus.Port_En !== 4'b0000) begin
      n_fail++; $display("FAIL ld_t2: Valid=%b En=%b, required 0000/0000", bus.Cgra_Load_Valid, bus.Port_En);
    end
    tick();
    n_chk++;
    if (bus.Cgra_Load_Valid !== 4'b0100) begin
      n_fail++; $display("FAIL ld_valid_t3: got %b, required 0100", bus.Cgra_Load_Valid);
    end
    n_chk++;
    if (bus.Cgra_Load[2] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL ld_data_t3: got %h, required deadbeef", bus.Cgra_Load[2]);
    end
    tick();
    n_chk++;
    if (bus.Cgra_Load_Valid !== 4'b0000) begin
      n_fail++; $display("FAIL ld_valid_t4: got %b, required 0000", bus.Cgra_Load_Valid);
    end
  endtask

  task automatic test_parallel_writes;
    logic [DW-1:0] exp_d;
    logic [AW-1:0] exp_a;
    for (int p = 0; p < NP; p++) begin
      bus.Cgra_Wen[p]   = 4'b0011;
      bus.Cgra_Store[p] = 32'h11223344 + DW'(p);
      bus.Cgra_Addr[p]  = AW'(p + 1);
    end
    bus.Cgra_Req = 4'hf;
    tick();
    bus.Cgra_Req = '0;
    n_chk++;
    if (bus.Port_En !== 4'hf) begin
      n_fail++; $display("FAIL wr_en: got %b, required 1111", bus.Port_En);
    end
    for (int p = 0; p < NP; p++) begin
      exp_d = 32'h11223344 + DW'(p);
      exp_a = AW'((p + 1) * 4);
      n_chk++;
      if (bus.Port_Wen[p] !== 4'b0011 || bus.Port_Data_To_Bram[p] !== exp_d || bus.Port_Addr[p] !== exp_a) begin
        n_fail++; $display("FAIL wr_port%0d: Wen=%b Data=%h Addr=%h, required 0011 %h %h",
                           p, bus.Port_Wen[p], bus.Port_Data_To_Bram[p], bus.Port_Addr[p], exp_d, exp_a);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (bus.Cgra_Load_Valid !== 4'b0000) begin
        n_fail++; $display("FAIL wr_no_load_valid: got %b at +%0d, required 0000", bus.Cgra_Load_Valid, i + 2);
      end
    end
    n_chk++;
    if (bus.Port_En !== 4'h0 || bus.Port_Wen[1] !== 4'b0000 || bus.Port_Data_To_Bram[1] !== 32'h11223345) begin
      n_fail++; $display("FAIL wr_hold: En=%b Wen1=%b Data1=%h, required 0000 0000 11223345",
                         bus.Port_En, bus.Port_Wen[1], bus.Port_Data_To_Bram[1]);
    end
    bus.Cgra_Wen = '0;
    bus.PE_Array_Busy = 1'b0;
    wait_done(10);
    n_chk++;
    if (bus.Timeout_Flag !== 1'b0) begin
      n_fail++; $display("FAIL wr_timeout_flag: got %b, required 0", bus.Timeout_Flag);
    end
    bus.Computation_Start = 1'b0;
    tick(); tick();
  endtask

  task automatic test_dropped;
    bus.Cgra_Req = 4'hf; bus.Cgra_Wen = '0;
    tick();
    tick();
    n_chk++;
    if (bus.Port_En !== 4'h0 || bus.Cgra_Load_Valid !== 4'h0) begin
      n_fail++; $display("FAIL drop_idle: En=%b Valid=%b, required 0000", bus.Port_En, bus.Cgra_Load_Valid);
    end
    bus.Cgra_Req = '0;
    bus.Computation_Start = 1'b1;
    tick(); tick();
    bus.PE_Array_Busy = 1'b1;
    tick();
    bus.PE_Array_Busy = 1'b0;
    wait_done(8);
    bus.Cgra_Req = 4'hf;
    tick();
    n_chk++;
    if (bus.Port_En !== 4'h0) begin
      n_fail++; $display("FAIL drop_done: En=%b, required 0000", bus.Port_En);
    end
    tick();
    n_chk++;
    if (bus.Port_En !== 4'h0 || bus.Cgra_Load_Valid !== 4'h0) begin
      n_fail++; $display("FAIL drop_done2: En=%b Valid=%b, required 0000", bus.Port_En, bus.Cgra_Load_Valid);
    end
    bus.Cgra_Req = '0;
    bus.Computation_Start = 1'b0;
    tick(); tick();
  endtask

  task automatic test_watchdog;
    // Busy never rises: RUN is cycles 2..21, timeout decided on cycle 21
    bus.Computation_Start = 1'b1;
    tick();
    for (int c = 2; c <= 24; c++) begin
      tick();
      if (c == 21) begin
        n_chk++;
        if (bus.Timeout_Flag !== 1'b0) begin
          n_fail++; $display("FAIL wd_flag_early: got %b, required 0", bus.Timeout_Flag);
        end
      end
      if (c == 22) begin
        n_chk++;
        if (bus.Timeout_Flag !== 1'b1 || bus.Run_Cycles !== 32'd19) begin
          n_fail++; $display("FAIL wd_fire: Flag=%b Run=%0d, required 1/19", bus.Timeout_Flag, bus.Run_Cycles);
        end
      end
      if (c == 23 || c == 24) begin
        n_chk++;
        if (bus.Computation_Done !== (c == 24)) begin
          n_fail++; $display("FAIL wd_done_c%0d: got %b, required %b", c, bus.Computation_Done, c == 24);
        end
      end
    end
    bus.Computation_Start = 1'b0;
    tick();
    n_chk++;
    if (bus.Computation_Done !== 1'b0 || bus.Timeout_Flag !== 1'b1) begin
      n_fail++; $display("FAIL wd_after: Done=%b Flag=%b, required 0/1", bus.Computation_Done, bus.Timeout_Flag);
    end
    tick();
    // Busy falls on the watchdog cycle (RUN cycle 20): normal finish wins
    bus.Computation_Start = 1'b1;
    tick();
    for (int c = 2; c <= 24; c++) begin
      tick();
      bus.PE_Array_Busy = (c >= 3 && c <= 20);
      if (c == 2) begin
        n_chk++;
        if (bus.Timeout_Flag !== 1'b0) begin
          n_fail++; $display("FAIL wd_flag_clear: got %b, required 0", bus.Timeout_Flag);
        end
      end
      if (c == 22) begin
        n_chk++;
        if (bus.Timeout_Flag !== 1'b0 || bus.Run_Cycles !== 32'd19) begin
          n_fail++; $display("FAIL wd_tie: Flag=%b Run=%0d, required 0/19", bus.Timeout_Flag, bus.Run_Cycles);
        end
      end
      if (c == 24) begin
        n_chk++;
        if (bus.Computation_Done !== 1'b1) begin
          n_fail++; $display("FAIL wd_tie_done: got %b, required 1", bus.Computation_Done);
        end
      end
    end
    bus.Computation_Start = 1'b0;
    tick(); tick();
  endtask

  task automatic test_early_start_drop;
    bus.Computation_Start = 1'b1;
    tick();
    bus.Computation_Start = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      tick();
      bus.PE_Array_Busy = (c >= 3 && c <= 4);
      if (c >= 7) begin
        n_chk++;
        if (bus.Computation_Done !== (c == 8)) begin
          n_fail++; $display("FAIL early_drop_c%0d: Done=%b, required %b", c, bus.Computation_Done, c == 8);
        end
      end
    end
    tick();
  endtask

  task automatic test_mid_reset;
    bus.Computation_Start = 1'b1;
    tick(); tick();
    bus.PE_Array_Busy = 1'b1;
    bus.Cgra_Req = 4'b0001; bus.Cgra_Wen = '0; bus.Cgra_Addr[0] = 32'h3;
    tick();
    bus.Cgra_Req = '0;
    n_chk++;
    if (bus.Port_En !== 4'b0001) begin
      n_fail++; $display("FAIL mr_pre_en: got %b, required 0001", bus.Port_En);
    end
    Resetn = 1'b0;
    #1;
    n_chk++;
    if (bus.Port_En !== 4'h0 || bus.Port_Addr[0] !== 32'h0 || bus.Run_Cycles !== 32'd0 ||
        bus.Computation_Done !== 1'b0 || bus.Array_Start !== 1'b0) begin
      n_fail++; $display("FAIL mr_async_clear: En=%b Addr0=%h Run=%0d Done=%b Start=%b, required all 0",
                         bus.Port_En, bus.Port_Addr[0], bus.Run_Cycles, bus.Computation_Done, bus.Array_Start);
    end
    tick(); tick();
    n_chk++;
    if (bus.Cgra_Load_Valid !== 4'h0 || bus.Port_Rst !== 4'hf) begin
      n_fail++; $display("FAIL mr_in_reset: Valid=%b Rst=%b, required 0000/1111", bus.Cgra_Load_Valid, bus.Port_Rst);
    end
    bus.PE_Array_Busy = 1'b0;
    Resetn = 1'b1;
    tick();
    n_chk++;
    if (bus.Array_Start !== 1'b1) begin
      n_fail++; $display("FAIL mr_restart: Array_Start=%b, required 1", bus.Array_Start);
    end
    tick();
    bus.PE_Array_Busy = 1'b1;
    tick();
    bus.PE_Array_Busy = 1'b0;
    wait_done(8);
    n_chk++;
    if (bus.Run_Cycles !== 32'd1 || bus.Timeout_Flag !== 1'b0) begin
      n_fail++; $display("FAIL mr_second_run: Run=%0d Flag=%b, required 1/0", bus.Run_Cycles, bus.Timeout_Flag);
    end
    bus.Computation_Start = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_load_latency();
    test_parallel_writes();
    test_dropped();
    test_watchdog();
    test_early_start_drop();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
